pipe_hazard_ctrl: RTL

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl_if.sv | 33 +++
 rtl/pipe_hazard_ctrl.sv | 122 ++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-unit signal bundle: ID-stage decode fields in, stall/flush/forwarding controls out.
// The master side is the pipeline datapath; the slave side is the hazard controller.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             fwd_en;
  logic             id_valid;
  logic [4:0]       id_src1;
  logic [4:0]       id_src2;
  logic             id_src2_used;
  logic [4:0]       id_dest;
  logic             id_wb_en;
  logic             id_mem_read;
  logic             br_taken;
  logic             stall;
  logic             bubble;
  logic             flush;
  logic [1:0]       fwd_sel1;
  logic [1:0]       fwd_sel2;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output fwd_en, id_valid, id_src1, id_src2, id_src2_used,
           id_dest, id_wb_en, id_mem_read, br_taken,
    input  stall, bubble, flush, fwd_sel1, fwd_sel2, stall_cnt
  );

  modport slave (
    input  fwd_en, id_valid, id_src1, id_src2, id_src2_used,
           id_dest, id_wb_en, id_mem_read, br_taken,
    output stall, bubble, flush, fwd_sel1, fwd_sel2, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Data/control hazard controller for a 5-stage pipeline: tracks the EXE and MEM producers,
// raises stall/bubble/flush, and registers forwarding selects for the instruction entering EXE.
module pipe_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input logic              clk,
  input logic              rst,
  pipe_hazard_ctrl_if.slave hz
);

  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
    logic       wb_en;
    logic       mem_read;
  } slot_t;

  localparam logic [1:0]       SEL_ID  = 2'b00;
  localparam logic [1:0]       SEL_MEM = 2'b01;
  localparam logic [1:0]       SEL_WB  = 2'b10;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  slot_t            exe_q;
  slot_t            mem_q;
  slot_t            exe_d;
  logic             use1;
  logic             use2;
  logic             exe_m1;
  logic             exe_m2;
  logic             mem_m1;
  logic             mem_m2;
  logic             hazard_raw;
  logic             hazard;
  logic             stall_c;
  logic             bubble_c;
  logic             flush_c;
  logic [1:0]       sel1_d;
  logic [1:0]       sel2_d;
  logic [1:0]       sel1_q;
  logic [1:0]       sel2_q;
  logic [CNT_W-1:0] cnt_q;

  // Register 0 is hard-wired, so a producer writing it never creates a dependency.
  function automatic logic slot_match(input slot_t s, input logic [4:0] r);
    return s.valid && s.wb_en && (s.dest == r) && (r != 5'd0);
  endfunction

  function automatic logic [1:0] pick_sel(input logic em, input logic mm);
    if (em)      return SEL_MEM;
    else if (mm) return SEL_WB;
    else         return SEL_ID;
  endfunction

  always_comb begin
    use1   = hz.id_valid;
    use2   = hz.id_valid && hz.id_src2_used;
    exe_m1 = use1 && slot_match(exe_q, hz.id_src1);
    exe_m2 = use2 && slot_match(exe_q, hz.id_src2);
    mem_m1 = use1 && slot_match(mem_q, hz.id_src1);
    mem_m2 = use2 && slot_match(mem_q, hz.id_src2);

    // With forwarding only a load still in EXE cannot supply its result in time.
    if (hz.fwd_en)
      hazard_raw = exe_q.mem_read && (exe_m1 || exe_m2);
    else
      hazard_raw = exe_m1 || exe_m2 || mem_m1 || mem_m2;
    hazard = hazard_raw && !rst;

    stall_c  = 1'b0;
    bubble_c = 1'b0;
    flush_c  = 1'b0;
    if (hz.br_taken) begin
      flush_c  = 1'b1;
      bubble_c = 1'b1;
    end else begin
      stall_c  = hazard;
      bubble_c = hazard;
    end
  end

  always_comb begin
    exe_d = '0;
    if (hz.id_valid && !bubble_c) begin
      exe_d.valid    = 1'b1;
      exe_d.dest     = hz.id_dest;
      exe_d.wb_en    = hz.id_wb_en;
      exe_d.mem_read = hz.id_mem_read;
    end

    sel1_d = SEL_ID;
    sel2_d = SEL_ID;
    if (hz.fwd_en && !bubble_c) begin
      sel1_d = pick_sel(exe_m1, mem_m1);
      sel2_d = pick_sel(exe_m2, mem_m2);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exe_q  <= '0;
      mem_q  <= '0;
      sel1_q <= SEL_ID;
      sel2_q <= SEL_ID;
      cnt_q  <= '0;
    end else begin
      exe_q  <= exe_d;
      mem_q  <= exe_q;
      sel1_q <= sel1_d;
      sel2_q <= sel2_d;
      if (stall_c && (cnt_q != '1))
        cnt_q <= cnt_q + CNT_ONE;
    end
  end

  assign hz.stall     = stall_c;
  assign hz.bubble    = bubble_c;
  assign hz.flush     = flush_c;
  assign hz.fwd_sel1  = sel1_q;
  assign hz.fwd_sel2  = sel2_q;
  assign hz.stall_cnt = cnt_q;

endmodule
